// File: rtl/flags_stack.sv
// flags_stack: privileged flag register with a trap save-stack.
// Low SYS_BITS flags are system (kernel-only writes); the rest are executable.
// A trap pushes the current flags and enters kernel mode; a return pops them.
// Overflow/underflow errors are sticky; privilege violations pulse for one cycle.
module flags_stack #(
   parameter int WIDTH    = 32,
   parameter int SYS_BITS = 16,
   parameter int KF_INDEX = 0,
   parameter int DEPTH    = 4
) (
   input  logic                         clk_i,
   input  logic                         arst_i,
   input  logic                         wr_en_i,
   input  logic [WIDTH-1:0]             wr_mask_i,
   input  logic [WIDTH-1:0]             flags_i,
   input  logic                         trap_i,
   input  logic                         ret_i,
   input  logic                         clr_err_i,
   output logic [WIDTH-1:0]             flags_o,
   output logic                         kernel_o,
   output logic [$clog2(DEPTH+1)-1:0]   depth_o,
   output logic                         ovf_o,
   output logic                         udf_o,
   output logic                         priv_viol_o
);

   localparam int DW = $clog2(DEPTH + 1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [DW-1:0]    DEPTH_MAX = DW'(DEPTH);
   localparam logic [DW-1:0]    DEPTH_ONE = DW'(1);
   localparam logic [WIDTH-1:0] RST_FLAGS = WIDTH'(1) << KF_INDEX;

   // Mask with a 1 in every system-flag position.
   function automatic logic [WIDTH-1:0] sys_mask_f();
      logic [WIDTH-1:0] m;
      for (int b = 0; b < WIDTH; b++) begin
         m[b] = (b < SYS_BITS);
      end
      return m;
   endfunction

   localparam logic [WIDTH-1:0] SYS_MASK = sys_mask_f();

   logic [WIDTH-1:0] flags_q, flags_d;
   logic [DW-1:0]    depth_q, depth_d;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;
   logic             viol_q, viol_d;

   logic [WIDTH-1:0] stack_q [DEPTH];
   logic             push;
   logic [IW-1:0]    push_idx;
   logic [IW-1:0]    pop_idx;
   logic             kernel;
   logic [WIDTH-1:0] eff_mask;

   assign kernel   = flags_q[KF_INDEX];
   assign push_idx = IW'(depth_q);
   assign pop_idx  = IW'(depth_q - DEPTH_ONE);

   // Next-state: error clear first so a same-cycle set overrides it, then one request by priority.
   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
      flags_d  = flags_q;
      depth_d  = depth_q;
      ovf_d    = ovf_q;
      udf_d    = udf_q;
      viol_d   = 1'b0;
      push     = 1'b0;
      eff_mask = '0;

      if (clr_err_i) begin
         if (kernel) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
         end else begin
            viol_d = 1'b1;
         end
      end

      if (trap_i) begin
         if (depth_q < DEPTH_MAX) begin
            push    = 1'b1;
            depth_d = depth_q + DEPTH_ONE;
         end else begin
            ovf_d = 1'b1;
         end
         flags_d[KF_INDEX] = 1'b1;
      end else if (ret_i) begin
         if (!kernel) begin
            viol_d = 1'b1;
         end else if (depth_q == '0) begin
            udf_d = 1'b1;
         end else begin
            flags_d = stack_q[pop_idx];
            depth_d = depth_q - DEPTH_ONE;
         end
      end else if (wr_en_i) begin
         eff_mask = kernel ? wr_mask_i : (wr_mask_i & ~SYS_MASK);
         flags_d  = (flags_q & ~eff_mask) | (flags_i & eff_mask);
         if (!kernel && ((wr_mask_i & SYS_MASK) != '0)) begin
            viol_d = 1'b1;
         end
      end
   end

   // Control and status registers, cleared asynchronously.
   always_ff @(posedge clk_i or posedge arst_i) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (arst_i) begin
         flags_q <= RST_FLAGS;
         depth_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
         viol_q  <= 1'b0;
      end else begin
         flags_q <= flags_d;
         depth_q <= depth_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
         viol_q  <= viol_d;
      end
   end

   // Save-stack storage, written only on an accepted push.
   always_ff @(posedge clk_i) begin
      // NOTE: storage is deliberately not reset; depth_q = 0 already marks every entry as invalid.
      if (push) begin
         stack_q[push_idx] <= flags_q;
      end
   end

   assign flags_o     = flags_q;
   assign kernel_o    = flags_q[KF_INDEX];
   assign depth_o     = depth_q;
   assign ovf_o       = ovf_q;
   assign udf_o       = udf_q;
   assign priv_viol_o = viol_q;

endmodule
